phase_arbiter: RTL

PHASE_ARBITER -- requirements
Module: phase_arbiter

---
 rtl/phase_arb_pkg.sv | 42 ++++
 rtl/phase_arbiter_timer.sv | 29 ++
 rtl/phase_arbiter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/phase_arb_pkg.sv
// phase_arb_pkg: shared definitions for the phase_arbiter traffic controller.
// Holds the state encoding, R/Y/G one-hot light constants and default durations.
package phase_arb_pkg;

    typedef logic [2:0] state_t;

    localparam state_t MAIN_G  = 3'd0;
    localparam state_t MAIN_Y  = 3'd1;
    localparam state_t ALLRED  = 3'd2;
    localparam state_t SIDE_G  = 3'd3;
    localparam state_t SIDE_Y  = 3'd4;
    localparam state_t WALK    = 3'd5;
    localparam state_t PREEMPT = 3'd6;

    localparam logic [2:0] LIGHT_R = 3'b100;
    localparam logic [2:0] LIGHT_Y = 3'b010;
    localparam logic [2:0] LIGHT_G = 3'b001;

    localparam int DEF_MIN_GREEN = 6;
    localparam int DEF_YELLOW_T  = 2;
    localparam int DEF_WALK_T    = 3;
    localparam int DEF_ALLRED_T  = 1;

    localparam logic LAST_SIDE = 1'b0;
    localparam logic LAST_WALK = 1'b1;

    // Returns {main_light, side_light, walk_light} for a state.
    function automatic logic [6:0] light_decode(state_t s);
        logic [6:0] l;
        l = {LIGHT_R, LIGHT_R, 1'b0};
        case (s)
            MAIN_G:  l = {LIGHT_G, LIGHT_R, 1'b0};
            MAIN_Y:  l = {LIGHT_Y, LIGHT_R, 1'b0};
            SIDE_G:  l = {LIGHT_R, LIGHT_G, 1'b0};
            SIDE_Y:  l = {LIGHT_R, LIGHT_Y, 1'b0};
            WALK:    l = {LIGHT_R, LIGHT_R, 1'b1};
            default: l = {LIGHT_R, LIGHT_R, 1'b0};
        endcase
        return l;
    endfunction

endpackage

// File: rtl/phase_arbiter_timer.sv
// phase_timer: 4-bit saturating tick counter with duration expire compare.
// Ports: clock, rst_n, clear (state entry), tick, dur[3:0]; expired out.
module phase_timer (
    input  logic       clock,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       tick,
    input  logic [3:0] dur,
    output logic       expired
);

    logic [3:0] count;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            count <= 4'd0;
        end else if (clear) begin
            count <= 4'd0;
        end else if (tick && count != 4'd15) begin
            count <= count + 4'd1;
        end
    end

    // Compare with >= so a green held past its minimum (no request yet)
    // still reports expiry on every later tick; timed phases leave on
    // the first expiry, where this equals count == dur-1.
    assign expired = tick && (count >= (dur - 4'd1));

endmodule

// File: rtl/phase_arbiter.sv
// phase_arbiter: main/side/walk traffic phase controller with tick timing.
// Ports: clock, rst_n, tick, req_side, req_walk, req_emerg in;
//        main_light[2:0], side_light[2:0], walk_light, phase[2:0] out.
// Optional emergency preempt enabled by defining PHASE_ARB_EMERG_EN.
module phase_arbiter
    import phase_arb_pkg::*;
#(
    parameter int MIN_GREEN = DEF_MIN_GREEN,
    parameter int YELLOW_T  = DEF_YELLOW_T,
    parameter int WALK_T    = DEF_WALK_T,
    parameter int ALLRED_T  = DEF_ALLRED_T
) (
    input  logic       clock,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       req_side,
    input  logic       req_walk,
    input  logic       req_emerg,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic       walk_light,
    output logic [2:0] phase
);

    localparam logic [3:0] GREEN_D  = 4'(MIN_GREEN);
    localparam logic [3:0] YELLOW_D = 4'(YELLOW_T);
    localparam logic [3:0] WALK_D   = 4'(WALK_T);
    localparam logic [3:0] ALLRED_D = 4'(ALLRED_T);

    state_t     state;
    state_t     state_nxt;
    state_t     grant;
    logic       pend_side;
    logic       pend_walk;
    logic       last_served;
    logic       to_main;
    logic       expired;
    logic       emerg;
    logic       enter;
    logic       enter_side;
    logic       enter_walk;
    logic [3:0] dur;

`ifdef PHASE_ARB_EMERG_EN
    assign emerg = req_emerg;
`else
    assign emerg = req_emerg & 1'b0;
`endif

    always_comb begin
        dur = 4'd15;
        unique case (state)
            MAIN_G, SIDE_G: dur = GREEN_D;
            MAIN_Y, SIDE_Y: dur = YELLOW_D;
            ALLRED:         dur = ALLRED_D;
            WALK:           dur = WALK_D;
            default:        dur = 4'd15;
        endcase
    end

    phase_timer u_timer (
        .clock   (clock),
        .rst_n   (rst_n),
        .clear   (enter),
        .tick    (tick),
        .dur     (dur),
        .expired (expired)
    );

    // After a side or walk phase (or a preempt) main is always served next.
    always_comb begin
        grant = MAIN_G;
        if (to_main) begin
            grant = MAIN_G;
        end else if (pend_side && pend_walk) begin
            grant = (last_served == LAST_WALK) ? SIDE_G : WALK;
        end else if (pend_side) begin
            grant = SIDE_G;
        end else if (pend_walk) begin
            grant = WALK;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            MAIN_G: begin
                if (emerg || (expired && (pend_side || pend_walk)))
                    state_nxt = MAIN_Y;
            end
            MAIN_Y: begin
                if (expired)
                    state_nxt = ALLRED;
            end
            ALLRED: begin
                if (emerg)
                    state_nxt = PREEMPT;
                else if (expired)
                    state_nxt = grant;
            end
            SIDE_G: begin
                if (emerg || expired)
                    state_nxt = SIDE_Y;
            end
            SIDE_Y, WALK: begin
                if (expired)
                    state_nxt = ALLRED;
            end
            PREEMPT: begin
                if (!emerg)
                    state_nxt = ALLRED;
            end
            default: state_nxt = MAIN_G;
        endcase
    end

    assign enter      = (state_nxt != state);
    assign enter_side = enter && (state_nxt == SIDE_G);
    assign enter_walk = enter && (state_nxt == WALK);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state       <= MAIN_G;
            pend_side   <= 1'b0;
            pend_walk   <= 1'b0;
            last_served <= LAST_WALK;
            to_main     <= 1'b0;
            main_light  <= LIGHT_G;
            side_light  <= LIGHT_R;
            walk_light  <= 1'b0;
        end else begin
            state <= state_nxt;
            // A request in the entry cycle re-arms the flag.
            pend_side <= req_side | (pend_side & ~enter_side);
            pend_walk <= req_walk | (pend_walk & ~enter_walk);
            if (enter_side)
                last_served <= LAST_SIDE;
            else if (enter_walk)
                last_served <= LAST_WALK;
            if (enter && state_nxt == ALLRED)
                to_main <= (state != MAIN_Y);
            {main_light, side_light, walk_light} <= light_decode(state_nxt);
        end
    end

    assign phase = state;

endmodule
